wb_arbiter: RTL and testbench

Two-master Wishbone classic arbiter that shares the single slave-side bus into the SoC address mux between the CPU instruction-fetch port (m0) and the CPU data/loader port (m1). Grants are round-robin and are held for the full `cyc` of the owner. A bus-timeout watchdog terminates cycles that never receive `ack`, such as accesses to unacknowledged or unmapped slaves, with a one-cycle error to the owner.

---
 rtl/wb_arbiter.sv | 174 +++++++++++++++++
 tb/tb_wb_arbiter.sv | 374 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_arbiter.sv
// Two-master Wishbone classic arbiter with round-robin grants held for the
// owner's full cycle, plus a bus watchdog that turns an unacknowledged
// strobe into a one-cycle error to the owning master.
module wb_arbiter #(
    parameter int WB_DATA_WIDTH  = 32,
    parameter int WB_ADDR_WIDTH  = 32,
    parameter int WB_SEL_WIDTH   = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                     clk_i,
    input  logic                     rst_i,

    // master 0: instruction fetch
    input  logic [WB_ADDR_WIDTH-1:0] wb_m0_addr_i,
    input  logic [WB_DATA_WIDTH-1:0] wb_m0_data_i,
    input  logic                     wb_m0_we_i,
    input  logic [WB_SEL_WIDTH-1:0]  wb_m0_sel_i,
    input  logic                     wb_m0_stb_i,
    input  logic                     wb_m0_cyc_i,
    output logic                     wb_m0_ack_o,
    output logic                     wb_m0_err_o,
    output logic [WB_DATA_WIDTH-1:0] wb_m0_data_o,

    // master 1: data / loader
    input  logic [WB_ADDR_WIDTH-1:0] wb_m1_addr_i,
    input  logic [WB_DATA_WIDTH-1:0] wb_m1_data_i,
    input  logic                     wb_m1_we_i,
    input  logic [WB_SEL_WIDTH-1:0]  wb_m1_sel_i,
    input  logic                     wb_m1_stb_i,
    input  logic                     wb_m1_cyc_i,
    output logic                     wb_m1_ack_o,
    output logic                     wb_m1_err_o,
    output logic [WB_DATA_WIDTH-1:0] wb_m1_data_o,

    // shared slave side toward the address mux
    output logic [WB_ADDR_WIDTH-1:0] wb_s_addr_o,
    output logic [WB_DATA_WIDTH-1:0] wb_s_data_o,
    output logic                     wb_s_we_o,
    output logic [WB_SEL_WIDTH-1:0]  wb_s_sel_o,
    output logic                     wb_s_stb_o,
    output logic                     wb_s_cyc_o,
    input  logic                     wb_s_ack_i,
    input  logic [WB_DATA_WIDTH-1:0] wb_s_data_i
);

    // Counter only needs to reach TIMEOUT_CYCLES; keep at least one bit so
    // the disabled (0) configuration still elaborates cleanly.
    localparam int               CNT_W       = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(TIMEOUT_CYCLES);
    localparam bit               WDOG_EN     = (TIMEOUT_CYCLES != 0);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    state_t           state_reg;
    logic             last_reg;     // most recent owner; 1 after reset so m0 wins the first tie
    logic [CNT_W-1:0] count_reg;    // wait states seen by the current strobe

    // Masters gathered into small arrays so the mux and per-master responses
    // can be written once.
    logic [1:0]               m_cyc;
    logic [1:0]               m_stb;
    logic [1:0]               m_we;
    logic [WB_ADDR_WIDTH-1:0] m_addr [2];
    logic [WB_DATA_WIDTH-1:0] m_data [2];
    logic [WB_SEL_WIDTH-1:0]  m_sel  [2];

    assign m_cyc     = {wb_m1_cyc_i, wb_m0_cyc_i};
    assign m_stb     = {wb_m1_stb_i, wb_m0_stb_i};
    assign m_we      = {wb_m1_we_i,  wb_m0_we_i};
    assign m_addr[0] = wb_m0_addr_i;
    assign m_addr[1] = wb_m1_addr_i;
    assign m_data[0] = wb_m0_data_i;
    assign m_data[1] = wb_m1_data_i;
    assign m_sel[0]  = wb_m0_sel_i;
    assign m_sel[1]  = wb_m1_sel_i;

    logic [1:0] grant;
    logic       owned;
    logic       owner_idx;
    logic       err_cycle;
    logic [1:0] ack_vec;
    logic [1:0] err_vec;

    assign grant     = {state_reg == OWN1, state_reg == OWN0};
    assign owned     = |grant;
    assign owner_idx = grant[1];

    // The error beat fires when the counter has reached the limit and the
    // slave is not answering in this very cycle (a late ack still wins).
    assign err_cycle = WDOG_EN && owned && (count_reg == TIMEOUT_VAL) && !wb_s_ack_i;

    // Per-master responses: only the owner ever sees ack or err.
    for (genvar gi = 0; gi < 2; gi++) begin : g_resp
        assign ack_vec[gi] = wb_s_ack_i & grant[gi];
        assign err_vec[gi] = err_cycle  & grant[gi];
    end

    assign wb_m0_ack_o  = ack_vec[0];
    assign wb_m1_ack_o  = ack_vec[1];
    assign wb_m0_err_o  = err_vec[0];
    assign wb_m1_err_o  = err_vec[1];

    // Read data is broadcast; ack qualifies it.
    assign wb_m0_data_o = wb_s_data_i;
    assign wb_m1_data_o = wb_s_data_i;

    // Slave side is a combinational copy of the owner, all-zero when idle,
    // with the strobe suppressed during the error beat.
    always_comb begin
        wb_s_addr_o = '0;
        wb_s_data_o = '0;
        wb_s_we_o   = 1'b0;
        wb_s_sel_o  = '0;
        wb_s_stb_o  = 1'b0;
        wb_s_cyc_o  = 1'b0;
        if (owned) begin
            wb_s_addr_o = m_addr[owner_idx];
            wb_s_data_o = m_data[owner_idx];
            wb_s_we_o   = m_we[owner_idx];
            wb_s_sel_o  = m_sel[owner_idx];
            wb_s_stb_o  = m_stb[owner_idx] & ~err_cycle;
            wb_s_cyc_o  = m_cyc[owner_idx];
        end
    end

    // Ownership FSM: round-robin on a tie, grant held until the owner drops cyc.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_reg <= IDLE;
            last_reg  <= 1'b1;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (m_cyc[0] && (!m_cyc[1] || last_reg)) begin
                        state_reg <= OWN0;
                        last_reg  <= 1'b0;
                    end else if (m_cyc[1]) begin
                        state_reg <= OWN1;
                        last_reg  <= 1'b1;
                    end
                end
                OWN0: begin
                    if (!m_cyc[0]) begin
                        state_reg <= IDLE;
                    end
                end
                OWN1: begin
                    if (!m_cyc[1]) begin
                        state_reg <= IDLE;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    // Watchdog: count unacknowledged strobes, restart on ack, error or idle.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_reg <= '0;
        end else if (!owned || wb_s_ack_i || err_cycle) begin
            count_reg <= '0;
        end else if (WDOG_EN && wb_s_cyc_o && wb_s_stb_o) begin
            count_reg <= count_reg + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: two instances (watchdog limit 4 and watchdog off)
// share one stimulus; a transaction-level model predicts every output.
module tb_wb_arbiter;

    localparam int DW = 32;
    localparam int AW = 32;
    localparam int SW = 4;
    localparam int TO = 4;

    logic clk = 1'b0;
    logic rst;

    logic [1:0]    m_cyc, m_stb, m_we;
    logic [AW-1:0] m_addr [2];
    logic [DW-1:0] m_wdat [2];
    logic [SW-1:0] m_sel  [2];
    logic          s_ack;
    logic [DW-1:0] s_rdat;

    logic [1:0]    a_ack, a_err;
    logic [DW-1:0] a_d0, a_d1, a_sdat;
    logic [AW-1:0] a_saddr;
    logic [SW-1:0] a_ssel;
    logic          a_swe, a_sstb, a_scyc;

    logic [1:0]    b_ack, b_err;
    logic [DW-1:0] b_d0, b_d1, b_sdat;
    logic [AW-1:0] b_saddr;
    logic [SW-1:0] b_ssel;
    logic          b_swe, b_sstb, b_scyc;

    int total = 0;
    int bad   = 0;

    // reference model: owner -1 means bus free
    int owner, last, waits;

    // values sampled mid-cycle by step()
    logic [1:0]    p_ack, p_err, p_b_ack, p_b_err;
    logic          p_scyc, p_sstb;
    logic [AW-1:0] p_saddr;
    logic [DW-1:0] p_d0;

    always #5 clk = ~clk;

    wb_arbiter #(.WB_DATA_WIDTH(DW), .WB_ADDR_WIDTH(AW), .WB_SEL_WIDTH(SW), .TIMEOUT_CYCLES(TO)) dut_a (
        .clk_i(clk), .rst_i(rst),
        .wb_m0_addr_i(m_addr[0]), .wb_m0_data_i(m_wdat[0]), .wb_m0_we_i(m_we[0]), .wb_m0_sel_i(m_sel[0]),
        .wb_m0_stb_i(m_stb[0]), .wb_m0_cyc_i(m_cyc[0]), .wb_m0_ack_o(a_ack[0]), .wb_m0_err_o(a_err[0]),
        .wb_m0_data_o(a_d0),
        .wb_m1_addr_i(m_addr[1]), .wb_m1_data_i(m_wdat[1]), .wb_m1_we_i(m_we[1]), .wb_m1_sel_i(m_sel[1]),
        .wb_m1_stb_i(m_stb[1]), .wb_m1_cyc_i(m_cyc[1]), .wb_m1_ack_o(a_ack[1]), .wb_m1_err_o(a_err[1]),
        .wb_m1_data_o(a_d1),
        .wb_s_addr_o(a_saddr), .wb_s_data_o(a_sdat), .wb_s_we_o(a_swe), .wb_s_sel_o(a_ssel),
        .wb_s_stb_o(a_sstb), .wb_s_cyc_o(a_scyc), .wb_s_ack_i(s_ack), .wb_s_data_i(s_rdat)
    );

    wb_arbiter #(.WB_DATA_WIDTH(DW), .WB_ADDR_WIDTH(AW), .WB_SEL_WIDTH(SW), .TIMEOUT_CYCLES(0)) dut_b (
        .clk_i(clk), .rst_i(rst),
        .wb_m0_addr_i(m_addr[0]), .wb_m0_data_i(m_wdat[0]), .wb_m0_we_i(m_we[0]), .wb_m0_sel_i(m_sel[0]),
        .wb_m0_stb_i(m_stb[0]), .wb_m0_cyc_i(m_cyc[0]), .wb_m0_ack_o(b_ack[0]), .wb_m0_err_o(b_err[0]),
        .wb_m0_data_o(b_d0),
        .wb_m1_addr_i(m_addr[1]), .wb_m1_data_i(m_wdat[1]), .wb_m1_we_i(m_we[1]), .wb_m1_sel_i(m_sel[1]),
        .wb_m1_stb_i(m_stb[1]), .wb_m1_cyc_i(m_cyc[1]), .wb_m1_ack_o(b_ack[1]), .wb_m1_err_o(b_err[1]),
        .wb_m1_data_o(b_d1),
        .wb_s_addr_o(b_saddr), .wb_s_data_o(b_sdat), .wb_s_we_o(b_swe), .wb_s_sel_o(b_ssel),
        .wb_s_stb_o(b_sstb), .wb_s_cyc_o(b_scyc), .wb_s_ack_i(s_ack), .wb_s_data_i(s_rdat)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        owner = -1;
        last  = 1;
        waits = 0;
    endtask

    function automatic logic model_err();
        return (owner >= 0) && (waits == TO) && !s_ack;
    endfunction

    // Compare every output of both instances against the model's view.
    task automatic check_cycle();
        logic          oi, e_cyc, e_stb, e_raw, e_err, e_we;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_dat;
        logic [SW-1:0] e_sel;
        logic [1:0]    e_ack, e_errv;
        oi = 1'b0; e_cyc = 1'b0; e_stb = 1'b0; e_raw = 1'b0; e_err = 1'b0; e_we = 1'b0;
        e_addr = '0; e_dat = '0; e_sel = '0; e_ack = '0; e_errv = '0;
        if (owner >= 0) begin
            oi        = owner[0];
            e_err     = model_err();
            e_cyc     = m_cyc[oi];
            e_raw     = m_stb[oi];
            e_stb     = e_raw && !e_err;
            e_we      = m_we[oi];
            e_addr    = m_addr[oi];
            e_dat     = m_wdat[oi];
            e_sel     = m_sel[oi];
            e_ack[oi] = s_ack;
            e_errv[oi] = e_err;
        end
        check("a_s_cyc",  64'(a_scyc),  64'(e_cyc));
        check("a_s_stb",  64'(a_sstb),  64'(e_stb));
        check("a_s_addr", 64'(a_saddr), 64'(e_addr));
        check("a_s_data", 64'(a_sdat),  64'(e_dat));
        check("a_s_we",   64'(a_swe),   64'(e_we));
        check("a_s_sel",  64'(a_ssel),  64'(e_sel));
        check("a_ack",    64'(a_ack),   64'(e_ack));
        check("a_err",    64'(a_err),   64'(e_errv));
        check("a_m0_rd",  64'(a_d0),    64'(s_rdat));
        check("a_m1_rd",  64'(a_d1),    64'(s_rdat));
        check("b_s_cyc",  64'(b_scyc),  64'(e_cyc));
        check("b_s_stb",  64'(b_sstb),  64'(e_raw));
        check("b_s_addr", 64'(b_saddr), 64'(e_addr));
        check("b_ack",    64'(b_ack),   64'(e_ack));
        check("b_err",    64'(b_err),   64'(0));
    endtask

    // Advance the model across one clock edge using the current inputs.
    task automatic model_update();
        logic oi;
        logic e_err;
        e_err = model_err();
        if (owner < 0) begin
            if (m_cyc == 2'b11)  owner = 1 - last;
            else if (m_cyc[0])   owner = 0;
            else if (m_cyc[1])   owner = 1;
            if (owner >= 0) begin
                last  = owner;
                waits = 0;
            end
        end else begin
            oi = owner[0];
            if (!m_cyc[oi]) begin
                owner = -1;
                waits = 0;
            end else if (s_ack || e_err) begin
                waits = 0;
            end else if (m_stb[oi]) begin
                waits++;
            end
        end
    endtask

    // One bus cycle: sample mid-cycle, check, then cross the edge.
    task automatic step();
        #2;
        p_ack   = a_ack;
        p_err   = a_err;
        p_b_ack = b_ack;
        p_b_err = b_err;
        p_scyc  = a_scyc;
        p_sstb  = a_sstb;
        p_saddr = a_saddr;
        p_d0    = a_d0;
        check_cycle();
        model_update();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        m_cyc = '0; m_stb = '0; m_we = '0;
        for (int i = 0; i < 2; i++) begin
            m_addr[i] = '0;
            m_wdat[i] = '0;
            m_sel[i]  = '0;
        end
        s_ack  = 1'b0;
        s_rdat = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle_inputs();
        model_reset();
        #1;
        check_cycle();
        @(posedge clk);
        #1;
        check_cycle();
        rst = 1'b0;
    endtask

    initial begin
        int n_err;
        int n_ack1;
        int rest [2];
        int order [$];
        bit gap_seen;
        int k1, k2;

        rst = 1'b1;
        idle_inputs();
        model_reset();
        do_reset();

        // A: m0 single read, zero-wait slave
        m_cyc = 2'b01; m_stb = 2'b01; m_addr[0] = 32'h0000_0040; m_sel[0] = 4'hF;
        step();
        check("A_cyc_req_cycle", 64'(p_scyc), 64'(0));
        s_ack = 1'b1; s_rdat = 32'h1234_5678;
        step();
        check("A_cyc_granted", 64'(p_scyc), 64'(1));
        check("A_ack", 64'(p_ack), 64'(2'b01));
        check("A_rdata", 64'(p_d0), 64'(32'h1234_5678));
        idle_inputs();
        step();
        step();

        // B: both masters, repeated one-beat writes, round-robin
        do_reset();
        rest[0] = 0; rest[1] = 0; gap_seen = 1'b1;
        for (int c = 0; c < 30; c++) begin
            for (int m = 0; m < 2; m++) begin
                m_cyc[m]  = (rest[m] == 0);
                m_stb[m]  = (rest[m] == 0);
                m_we[m]   = 1'b1;
                m_sel[m]  = 4'hF;
                m_addr[m] = (m == 0) ? (32'h1000_0000 | 32'(c)) : (32'h2000_0000 | 32'(c));
                m_wdat[m] = $urandom;
            end
            #1;
            s_ack = a_scyc && a_sstb;
            step();
            for (int m = 0; m < 2; m++) begin
                if (p_ack[m]) begin
                    if (order.size() > 0) check("B_gap_between_grants", 64'(gap_seen), 64'(1));
                    check("B_slave_addr_from_owner", 64'(p_saddr), 64'(m_addr[m]));
                    order.push_back(m);
                    gap_seen = 1'b0;
                    rest[m]  = 1;
                end else if (rest[m] > 0) begin
                    rest[m]--;
                end
            end
            if (!p_scyc) gap_seen = 1'b1;
        end
        check("B_grant_count_ge8", 64'(order.size() >= 8), 64'(1));
        for (int i = 0; i < 8 && i < order.size(); i++) begin
            check("B_grant_order", 64'(order[i]), 64'(i % 2));
        end
        idle_inputs();
        step();
        step();

        // C: m1 three-beat burst while m0 waits
        m_cyc = 2'b10; m_stb = 2'b10; m_addr[1] = 32'h100; m_addr[0] = 32'h0000_0BAD;
        step();
        n_ack1 = 0;
        for (int b = 0; b < 3; b++) begin
            m_cyc = 2'b11; m_stb = 2'b11;
            m_addr[1] = 32'h100 + 32'(4 * b);
            s_ack = 1'b1; s_rdat = $urandom;
            step();
            check("C_beat_addr", 64'(p_saddr), 64'(32'h100 + 32'(4 * b)));
            check("C_m0_no_ack", 64'(p_ack[0]), 64'(0));
            if (p_ack[1]) n_ack1++;
        end
        check("C_m1_acks", 64'(n_ack1), 64'(3));
        m_cyc = 2'b01; m_stb = 2'b01; s_ack = 1'b0;
        step();
        check("C_release_cycle_cyc", 64'(p_scyc), 64'(0));
        step();
        check("C_idle_cycle_cyc", 64'(p_scyc), 64'(0));
        s_ack = 1'b1;
        step();
        check("C_m0_granted_ack", 64'(p_ack), 64'(2'b01));
        check("C_m0_addr", 64'(p_saddr), 64'(32'h0000_0BAD));
        idle_inputs();
        step();

        // D: timeout on an unmapped address, stb held high
        m_cyc = 2'b01; m_stb = 2'b01; m_addr[0] = 32'hDEAD_0000;
        step();
        n_err = 0; k1 = -1; k2 = -1;
        for (int k = 0; k < 12; k++) begin
            step();
            check("D_err_timing", 64'(p_err[0]), 64'((k == 4) || (k == 9)));
            check("D_stb_masked", 64'(p_sstb), 64'(!((k == 4) || (k == 9))));
            check("D_no_ack", 64'(p_ack), 64'(0));
            if (p_err[0]) begin
                n_err++;
                if (k1 < 0) k1 = k; else k2 = k;
            end
        end
        check("D_err_count", 64'(n_err), 64'(2));
        check("D_first_err", 64'(k1), 64'(4));
        check("D_second_err", 64'(k2), 64'(9));
        idle_inputs();
        step();

        // E: ack arriving exactly at the limit wins over err
        m_cyc = 2'b01; m_stb = 2'b01; m_addr[0] = 32'h0000_0500;
        step();
        for (int k = 0; k <= 4; k++) begin
            s_ack = (k == 4);
            step();
            check("E_ack_at_limit", 64'(p_ack[0]), 64'(k == 4));
            check("E_no_err", 64'(p_err[0]), 64'(0));
        end
        idle_inputs();
        step();

        // E0: watchdog disabled, 1000 wait states
        m_cyc = 2'b01; m_stb = 2'b01; m_addr[0] = 32'h0000_0600;
        step();
        n_err = 0;
        for (int k = 0; k < 1000; k++) begin
            step();
            if (p_b_err != 2'b00) n_err++;
        end
        check("E0_err_count", 64'(n_err), 64'(0));
        s_ack = 1'b1;
        step();
        check("E0_late_ack", 64'(p_b_ack), 64'(2'b01));
        idle_inputs();
        step();

        // F: reset in the middle of an m1 burst
        m_cyc = 2'b10; m_stb = 2'b10; m_addr[1] = 32'h0000_0700; m_sel[1] = 4'h3;
        step();
        s_ack = 1'b1;
        step();
        #2;
        rst = 1'b1;
        #1;
        check("F_rst_s_cyc", 64'(a_scyc), 64'(0));
        check("F_rst_s_stb", 64'(a_sstb), 64'(0));
        check("F_rst_s_addr", 64'(a_saddr), 64'(0));
        check("F_rst_s_sel", 64'(a_ssel), 64'(0));
        check("F_rst_ack", 64'({a_ack, b_ack}), 64'(0));
        model_reset();
        idle_inputs();
        @(posedge clk);
        #1;
        rst = 1'b0;
        m_cyc = 2'b11; m_stb = 2'b11; m_addr[0] = 32'h0000_0800; m_addr[1] = 32'h0000_0900;
        step();
        s_ack = 1'b1;
        step();
        check("F_first_grant_m0", 64'(p_ack), 64'(2'b01));
        idle_inputs();
        step();
        step();

        // R: randomized traffic against the model
        for (int c = 0; c < 1500; c++) begin
            for (int m = 0; m < 2; m++) begin
                if ($urandom_range(0, 7) == 0) m_cyc[m] = ~m_cyc[m];
                m_stb[m]  = m_cyc[m] && ($urandom_range(0, 3) != 0);
                m_we[m]   = 1'($urandom);
                m_addr[m] = $urandom;
                m_wdat[m] = $urandom;
                m_sel[m]  = 4'($urandom);
            end
            s_ack  = ($urandom_range(0, 3) == 0);
            s_rdat = $urandom;
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
